// File: rtl/frame_tx_sequencer.sv
// Frame readout sequencer: gates camera capture on VSYNC, then streams one frame of RAM bytes
// to a UART through a start/busy handshake. Optional sync header under FRAME_SYNC_HDR_EN.
module frame_tx_sequencer #(
  parameter int unsigned BYTES_PER_FRAME = 6144,
  parameter int unsigned ADDR_W          = 15,
  parameter int unsigned PRE_SEND_CYCLES = 125000,
  parameter int unsigned BYTE_GAP_CYCLES = 1085,
  parameter int unsigned CNT_W           = 21
) (
  input  logic              Clk,
  input  logic              i_Rst,
  input  logic              i_VS,
  input  logic [7:0]        i_RAM_Data,
  input  logic              i_Tx_Busy,
  output logic [ADDR_W-1:0] o_Read_Adress,
  output logic [7:0]        o_Tx_Data,
  output logic              o_Tx_Start,
  output logic              o_Capture_En,
  output logic              o_Frame_Indicator,
  output logic              o_Frame_Done
);

  typedef enum logic [2:0] {
    StArm,
    StHold,
    StLoad,
    StStart,
    StTxw,
    StGap,
    StDrain
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(BYTES_PER_FRAME - 1);
  localparam logic [CNT_W-1:0]  HoldLast  = CNT_W'(PRE_SEND_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GapLast   = CNT_W'(BYTE_GAP_CYCLES - 1);

  // VSYNC synchroniser and edge detector
  logic       vs_meta_q, vs_sync_q, vs_prev_q;
  logic [2:0] vs_valid_q;
  logic       vs_rise, vs_fall;

  always_ff @(posedge Clk or posedge i_Rst) begin
    if (i_Rst) begin
      vs_meta_q  <= 1'b0;
      vs_sync_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      vs_valid_q <= 3'b000;
    end else begin
      vs_meta_q  <= i_VS;
      vs_sync_q  <= vs_meta_q;
      vs_prev_q  <= vs_sync_q;
      vs_valid_q <= {vs_valid_q[1:0], 1'b1};
    end
  end

  // Edges only count once prev holds a real pin sample, so VS high at reset release is not a rise.
  assign vs_rise = vs_valid_q[2] & vs_sync_q & ~vs_prev_q;
  assign vs_fall = vs_valid_q[2] & ~vs_sync_q & vs_prev_q;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                tx_start_q, tx_start_d;
  logic                frame_done_q, frame_done_d;
  logic                capture_en_q, frame_ind_q;
  logic                hdr_pending;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      StArm: begin
        if (vs_rise) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (cnt_q >= HoldLast) begin
          state_d = StLoad;
          cnt_d   = '0;
          addr_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLoad: begin
        state_d = StStart;
      end
      StStart: begin
        if (!i_Tx_Busy) begin
          tx_start_d = 1'b1;
          state_d    = StTxw;
          cnt_d      = '0;
        end
      end
      StTxw: begin
        // First cycle is skipped: busy only rises the cycle after the start pulse.
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else if (!i_Tx_Busy) begin
          // The cycle busy is seen low already counts as the first gap cycle.
          state_d = StGap;
          cnt_d   = CNT_W'(1);
        end
      end
      StGap: begin
        if (cnt_q >= GapLast) begin
          cnt_d = '0;
          if (hdr_pending) begin
            state_d = StLoad;
          end else if (addr_q < LastAddr) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StLoad;
          end else begin
            frame_done_d = 1'b1;
            addr_d       = '0;
            state_d      = StDrain;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDrain: begin
        if (vs_fall) begin
          state_d = StArm;
        end
      end
      default: begin
        state_d = StArm;
        cnt_d   = '0;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= StArm;
      cnt_q        <= '0;
      addr_q       <= '0;
      tx_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      capture_en_q <= 1'b1;
      frame_ind_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      tx_start_q   <= tx_start_d;
      frame_done_q <= frame_done_d;
      capture_en_q <= (state_d == StArm);
      frame_ind_q  <= (state_d == StArm);
    end
  end

`ifdef FRAME_SYNC_HDR_EN
  // hdr_q: 0 = 0xFF byte, 1 = 0x00 byte, 2 = RAM data
  logic [1:0] hdr_q, hdr_d;

  always_comb begin
    hdr_d = hdr_q;
    if (state_q == StHold && state_d == StLoad) begin
      hdr_d = 2'd0;
    end else if (state_q == StGap && state_d == StLoad && hdr_pending) begin
      hdr_d = hdr_q + 2'd1;
    end
  end

  always_ff @(posedge Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hdr_q <= 2'd2;
    end else begin
      hdr_q <= hdr_d;
    end
  end

  assign hdr_pending = (hdr_q != 2'd2);

  always_comb begin
    case (hdr_q)
      2'd0:    o_Tx_Data = 8'hFF;
      2'd1:    o_Tx_Data = 8'h00;
      default: o_Tx_Data = i_RAM_Data;
    endcase
  end
`else
  assign hdr_pending = 1'b0;
  assign o_Tx_Data   = i_RAM_Data;
`endif

  assign o_Read_Adress     = addr_q;
  assign o_Tx_Start        = tx_start_q;
  assign o_Capture_En      = capture_en_q;
  assign o_Frame_Indicator = frame_ind_q;
  assign o_Frame_Done      = frame_done_q;

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// Bench for frame_tx_sequencer: byte-stream scoreboard with timing model, directed scenarios.
module tb_frame_tx_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned P  = 10;
  localparam int unsigned G  = 3;
  localparam int unsigned B  = 5;
  localparam int unsigned AW = 15;
`ifdef FRAME_SYNC_HDR_EN
  localparam int NB = N + 2;
`else
  localparam int NB = N;
`endif
  // VS set (cycle v) -> HOLD at v+3 -> first start P+2 later
  localparam int FirstLat   = P + 5;
  localparam int BytePeriod = B + G + 3;
  localparam int DoneLat    = B + G + 1;

  logic          Clk;
  logic          i_Rst;
  logic          i_VS;
  logic [7:0]    i_RAM_Data;
  logic          i_Tx_Busy;
  logic [AW-1:0] o_Read_Adress;
  logic [7:0]    o_Tx_Data;
  logic          o_Tx_Start;
  logic          o_Capture_En;
  logic          o_Frame_Indicator;
  logic          o_Frame_Done;

  frame_tx_sequencer #(
    .BYTES_PER_FRAME(N),
    .ADDR_W         (AW),
    .PRE_SEND_CYCLES(P),
    .BYTE_GAP_CYCLES(G),
    .CNT_W          (21)
  ) dut (
    .Clk              (Clk),
    .i_Rst            (i_Rst),
    .i_VS             (i_VS),
    .i_RAM_Data       (i_RAM_Data),
    .i_Tx_Busy        (i_Tx_Busy),
    .o_Read_Adress    (o_Read_Adress),
    .o_Tx_Data        (o_Tx_Data),
    .o_Tx_Start       (o_Tx_Start),
    .o_Capture_En     (o_Capture_En),
    .o_Frame_Indicator(o_Frame_Indicator),
    .o_Frame_Done     (o_Frame_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // RAM and UART behavioural models
  logic [7:0] mem [N] = '{8'hA5, 8'h3C, 8'h0F, 8'h81};
  int   busy_cnt = 0;
  logic busy_force = 1'b0;
  assign i_Tx_Busy = busy_force || (busy_cnt != 0);

  initial i_RAM_Data = 8'h00;
  always @(posedge Clk) begin
    if (o_Tx_Start) busy_cnt <= B;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    i_RAM_Data <= (o_Read_Adress < AW'(N)) ? mem[o_Read_Adress[1:0]] : 8'hEE;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected (address, data) per start pulse, plus predicted event cycles
  int         exp_addr[$];
  logic [7:0] exp_data[$];
  int         start_log[$];
  int         exp_next_start = -1;
  int         exp_done = -1;
  int         last_done_cyc = -1;
  int         n_starts = 0;
  int         n_done = 0;
  logic       prev_start = 1'b0;

  task automatic load_frame();
    exp_addr.delete();
    exp_data.delete();
`ifdef FRAME_SYNC_HDR_EN
    exp_addr.push_back(0); exp_data.push_back(8'hFF);
    exp_addr.push_back(0); exp_data.push_back(8'h00);
`endif
    for (int i = 0; i < int'(N); i++) begin
      exp_addr.push_back(i);
      exp_data.push_back(mem[i]);
    end
  endtask

  always @(negedge Clk) begin
    if (i_Rst) begin
      prev_start = 1'b0;
    end else begin
      if (o_Tx_Start) begin
        n_starts++;
        start_log.push_back(cyc);
        check("start_while_busy", i_Tx_Busy, 1'b0);
        check("start_back_to_back", prev_start, 1'b0);
        check("start_time", cyc, exp_next_start);
        check("start_expected", exp_addr.size() > 0, 1'b1);
        if (exp_addr.size() > 0) begin
          check("start_addr", o_Read_Adress, exp_addr.pop_front());
          check("start_data", o_Tx_Data, exp_data.pop_front());
          if (exp_addr.size() > 0) begin
            exp_next_start = cyc + BytePeriod;
          end else begin
            exp_next_start = -1;
            exp_done = cyc + DoneLat;
          end
        end
      end else if (cyc == exp_next_start) begin
        check("start_missing", o_Tx_Start, 1'b1);
      end
      if (o_Frame_Done) begin
        n_done++;
        last_done_cyc = cyc;
        check("done_time", cyc, exp_done);
        check("done_addr_zero", o_Read_Adress, 0);
        check("done_all_sent", exp_addr.size(), 0);
        exp_done = -1;
      end else if (cyc == exp_done) begin
        check("done_missing", o_Frame_Done, 1'b1);
      end
      check("indicator_eq_capture", o_Frame_Indicator, o_Capture_En);
      prev_start = o_Tx_Start;
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, o_Read_Adress, 0);
    check({tag, "_start"}, o_Tx_Start, 1'b0);
    check({tag, "_capture"}, o_Capture_En, 1'b1);
    check({tag, "_indicator"}, o_Frame_Indicator, 1'b1);
    check({tag, "_done"}, o_Frame_Done, 1'b0);
  endtask

  task automatic begin_frame(output int v);
    i_VS = 1'b0;
    repeat (5) step();
    load_frame();
    i_VS = 1'b1;
    v = cyc;
  endtask

  task automatic return_to_arm();
    int f;
    i_VS = 1'b0;
    f = cyc;
    step();
    step();
    check("drain_before_fall", o_Frame_Indicator, 1'b0);
    step();
    check("arm_after_fall_ind", o_Frame_Indicator, 1'b1);
    check("arm_after_fall_cap", o_Capture_En, 1'b1);
    check("arm_fall_latency", cyc - f, 3);
  endtask

  initial begin
    int v;
    int base;
    int done0;
    i_Rst = 1'b1;
    i_VS  = 1'b1;
    repeat (3) @(posedge Clk);
    #2;
    check_reset_outputs("reset");
    i_Rst = 1'b0;

    // VS already high at reset release: no edge, stays armed
    repeat (100) step();
    check("vs_high_capture", o_Capture_En, 1'b1);
    check("vs_high_indicator", o_Frame_Indicator, 1'b1);
    check("vs_high_no_start", n_starts, 0);

    // Frame 1 with a spurious VS fall/rise during TXW/GAP
    begin_frame(v);
    exp_next_start = v + FirstLat;
    base  = n_starts;
    done0 = n_done;
    for (int k = 0; k < 300 && n_done == done0; k++) begin
      step();
      if (cyc == v + 2) check("capture_before_hold", o_Capture_En, 1'b1);
      if (cyc == v + 3) check("capture_falls_hold", o_Capture_En, 1'b0);
      if (cyc == v + FirstLat + 1) i_VS = 1'b0;
      if (cyc == v + FirstLat + 5) i_VS = 1'b1;
    end
    check("f1_done_count", n_done, done0 + 1);
    check("f1_byte_count", n_starts - base, NB);
    check("f1_first_latency", start_log[base] - v, 15);
    check("f1_byte_period", start_log[base + 1] - start_log[base], 11);
    check("f1_done_latency", last_done_cyc - start_log[base + NB - 1], 9);
    repeat (30) step();
    check("f1_no_restart", n_starts - base, NB);
    check("drain_capture_off", o_Capture_En, 1'b0);
    return_to_arm();

    // Frame 2: busy held high through START for 50 cycles, then reset after 2nd byte
    begin_frame(v);
    exp_next_start = v + P + 54;
    base = n_starts;
    for (int k = 0; k < 300 && n_starts < base + 2; k++) begin
      step();
      if (cyc == v + 3 + P) busy_force = 1'b1;
      if (cyc == v + P + 53) busy_force = 1'b0;
    end
    check("f2_two_bytes", n_starts - base, 2);
    check("f2_start_after_busy", start_log[base] - v, 64);
    repeat (3) step();
    done0 = n_done;
    i_Rst = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    exp_addr.delete();
    exp_data.delete();
    exp_next_start = -1;
    exp_done = -1;
    repeat (2) step();
    i_Rst = 1'b0;
    check("no_partial_done", n_done, done0);

    // Frame 3: restart from address 0 after reset
    begin_frame(v);
    exp_next_start = v + FirstLat;
    base  = n_starts;
    done0 = n_done;
    for (int k = 0; k < 300 && n_done == done0; k++) step();
    check("f3_done_count", n_done, done0 + 1);
    check("f3_byte_count", n_starts - base, NB);
    check("f3_first_latency", start_log[base] - v, 15);
    return_to_arm();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
